// File: rtl/div_share_ctrl.sv
// div_share_ctrl
//   Round-robin arbiter and sequencer that shares one 4-cycle divider among
//   NUM_REQ requesters. It accepts one (a, b, tag) request at a time and runs
//   the divider for exactly one 4-cycle operation. The quotient is returned
//   with the requester id and tag. A zero divisor skips the divider and
//   returns a saturated quotient with the dz flag set.
//
// Ports
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_req_valid/o_req_ready  per-requester handshake (ready one-hot or zero)
//   i_req_a/b/tag         packed per-requester operands (slice k = requester k)
//   o_rsp_*/i_rsp_ready   response channel (id, tag, result, dz)
//   o_div_a/b/en/clr      divider drive; o_div_clr is the divider's reset
//   i_div_fin/result      divider finish flag and quotient
//   o_err                 sticky protocol error (fin outside DONE, or missing in DONE)
module div_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [16*NUM_REQ-1:0]    i_req_a,
  input  logic [16*NUM_REQ-1:0]    i_req_b,
  input  logic [TAG_W*NUM_REQ-1:0] i_req_tag,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [TAG_W-1:0]         o_rsp_tag,
  output logic [15:0]              o_rsp_result,
  output logic                     o_rsp_dz,
  output logic [15:0]              o_div_a,
  output logic [15:0]              o_div_b,
  output logic                     o_div_en,
  output logic                     o_div_clr,
  input  logic                     i_div_fin,
  input  logic [15:0]              i_div_result,
  output logic                     o_err
);

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY1, BUSY2, DONE, RESP} state_t;

  state_t r_state, w_next;

  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_id;
  logic [TAG_W-1:0] r_tag;
  logic [15:0]      r_div_a, r_div_b, r_result;
  logic             r_dz, r_err, r_div_clr;

  logic [15:0]      w_a   [NUM_REQ];
  logic [15:0]      w_b   [NUM_REQ];
  logic [TAG_W-1:0] w_tag [NUM_REQ];

  logic [ID_W-1:0]  w_idx, w_win;
  logic             w_found, w_accept, w_b_zero;
  logic [15:0]      w_sel_a, w_sat;

  genvar g;
  for (g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_a[g]   = i_req_a[16*g +: 16];
    assign w_b[g]   = i_req_b[16*g +: 16];
    assign w_tag[g] = i_req_tag[TAG_W*g +: TAG_W];
  end

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_idx = ID_W'((32'(r_rr_ptr) + i) % NUM_REQ);
      if (!w_found && i_req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // While the divider clear is still high, no grant is given.
  assign w_accept = (r_state == IDLE) && !r_div_clr && w_found;
  assign w_b_zero = (w_b[w_win] == '0);
  assign w_sel_a  = w_a[w_win];
  assign w_sat    = w_sel_a[15]      ? 16'h8000 :
                    (w_sel_a == '0)  ? 16'h0000 : 16'h7FFF;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = w_b_zero ? RESP : ISSUE;
      ISSUE:   w_next = BUSY1;
      BUSY1:   w_next = BUSY2;
      BUSY2:   w_next = DONE;
      DONE:    w_next = RESP;
      RESP:    if (i_rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = '0;
    if (w_accept) o_req_ready[w_win] = 1'b1;
    o_div_en    = (r_state == ISSUE) || (r_state == BUSY1) ||
                  (r_state == BUSY2) || (r_state == DONE);
    o_rsp_valid = (r_state == RESP);
  end

  // Follows reset with one cycle of lag, so the divider is cleared for the
  // reset cycles plus one, including a reset in mid-operation.
  always_ff @(posedge i_clk) begin
    r_div_clr <= ~i_rst_n;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rr_ptr <= ID_W'(NUM_REQ - 1);
      r_id     <= '0;
      r_tag    <= '0;
      r_div_a  <= '0;
      r_div_b  <= '0;
      r_result <= '0;
      r_dz     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rr_ptr <= w_win;
        r_id     <= w_win;
        r_tag    <= w_tag[w_win];
        r_div_a  <= w_a[w_win];
        r_div_b  <= w_b[w_win];
        r_dz     <= w_b_zero;
        if (w_b_zero) r_result <= w_sat;
      end
      if (r_state == DONE) begin
        r_result <= i_div_result;
        if (!i_div_fin) r_err <= 1'b1;
      end else if (i_div_fin) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_rsp_id     = r_id;
  assign o_rsp_tag    = r_tag;
  assign o_rsp_result = r_result;
  assign o_rsp_dz     = r_dz;
  assign o_div_a      = r_div_a;
  assign o_div_b      = r_div_b;
  assign o_div_clr    = r_div_clr;
  assign o_err        = r_err;

endmodule
